// File: rtl/alu_op_scheduler.sv
// Sequencer between the switch front end and the 6-bit ALU: runs one op or a four-op sweep
// and offers each result on a valid/ready handshake. Optional macro: ALU_SCHED_DIVZERO_EN.
module alu_op_scheduler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [5:0]  A_i,
  input  logic [5:0]  B_i,
  input  logic [1:0]  op_i,
  input  logic        sweep_i,
  output logic [5:0]  alu_A_o,
  output logic [5:0]  alu_B_o,
  output logic [1:0]  alu_op_o,
  input  logic [11:0] alu_data_i,
  output logic [11:0] result_o,
  output logic [1:0]  result_op_o,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic        busy_o,
  output logic        div_zero_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [5:0]  r_A;
  logic [5:0]  r_B;
  logic [1:0]  r_op;
  logic        r_sweep;
  logic [11:0] r_result;
  logic [1:0]  r_resultOp;
  logic        r_divZero;

  logic        w_accept;
  logic        w_transfer;
  logic        w_lastOp;
  logic        w_divZero;
  logic [11:0] w_sampleData;

  assign w_accept   = (r_state == S_IDLE) && start_i;
  assign w_transfer = (r_state == S_HOLD) && result_ready_i;
  assign w_lastOp   = !r_sweep || (r_op == 2'b11);

`ifdef ALU_SCHED_DIVZERO_EN
  // A zero divisor replaces the ALU's divide output with all ones and raises the sticky flag.
  assign w_divZero    = (r_op == 2'b11) && (r_B == 6'd0);
  assign w_sampleData = w_divZero ? 12'hFFF : alu_data_i;
`else
  assign w_divZero    = 1'b0;
  assign w_sampleData = alu_data_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (start_i) w_nextState = S_DRIVE;
      S_DRIVE:  w_nextState = S_SAMPLE;
      S_SAMPLE: w_nextState = S_HOLD;
      S_HOLD: begin
        if (result_ready_i) begin
          w_nextState = w_lastOp ? S_IDLE : S_DRIVE;
        end
      end
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Operand/opcode latches double as the ALU drive, so they hold their values back in IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_A        <= 6'd0;
      r_B        <= 6'd0;
      r_op       <= 2'd0;
      r_sweep    <= 1'b0;
      r_result   <= 12'd0;
      r_resultOp <= 2'd0;
      r_divZero  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_A       <= A_i;
        r_B       <= B_i;
        r_sweep   <= sweep_i;
        r_op      <= sweep_i ? 2'b00 : op_i;
        r_divZero <= 1'b0;
      end
      if (r_state == S_SAMPLE) begin
        r_result   <= w_sampleData;
        r_resultOp <= r_op;
        if (w_divZero) begin
          r_divZero <= 1'b1;
        end
      end
      if (w_transfer && !w_lastOp) begin
        r_op <= r_op + 2'd1;
      end
    end
  end

  assign alu_A_o        = r_A;
  assign alu_B_o        = r_B;
  assign alu_op_o       = r_op;
  assign result_o       = r_result;
  assign result_op_o    = r_resultOp;
  assign result_valid_o = (r_state == S_HOLD);
  assign busy_o         = (r_state != S_IDLE);
  assign div_zero_o     = r_divZero;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler: behavioural ALU plus a transaction-level schedule model.
module tb_alu_op_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [5:0]  A_i = 6'd0;
  logic [5:0]  B_i = 6'd0;
  logic [1:0]  op_i = 2'd0;
  logic        sweep_i = 1'b0;
  logic [5:0]  alu_A_o;
  logic [5:0]  alu_B_o;
  logic [1:0]  alu_op_o;
  logic [11:0] alu_data_i;
  logic [11:0] result_o;
  logic [1:0]  result_op_o;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic        busy_o;
  logic        div_zero_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  alu_op_scheduler dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .A_i(A_i),
    .B_i(B_i),
    .op_i(op_i),
    .sweep_i(sweep_i),
    .alu_A_o(alu_A_o),
    .alu_B_o(alu_B_o),
    .alu_op_o(alu_op_o),
    .alu_data_i(alu_data_i),
    .result_o(result_o),
    .result_op_o(result_op_o),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .busy_o(busy_o),
    .div_zero_o(div_zero_o)
  );

  // Behavioural ALU: add/sub zero-extended, mult full width, div packed {remainder, quotient}.
  function automatic logic [11:0] aluModel(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op);
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    case (op)
      2'b00:   return 12'(ia + ib);
      2'b01:   return {6'd0, 6'(ia - ib)};
      2'b10:   return 12'(ia * ib);
      default: return (ib == 0) ? {a, 6'h3F} : {6'(ia % ib), 6'(ia / ib)};
    endcase
  endfunction

  always_comb alu_data_i = aluModel(alu_A_o, alu_B_o, alu_op_o);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".alu_A"}, 32'(alu_A_o), 32'd0);
    checkOutput({tag, ".alu_B"}, 32'(alu_B_o), 32'd0);
    checkOutput({tag, ".alu_op"}, 32'(alu_op_o), 32'd0);
    checkOutput({tag, ".result"}, 32'(result_o), 32'd0);
    checkOutput({tag, ".result_op"}, 32'(result_op_o), 32'd0);
    checkOutput({tag, ".valid"}, 32'(result_valid_o), 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, ".div_zero"}, 32'(div_zero_o), 32'd0);
  endtask

  // Junk on the start/operand inputs while busy must never be captured.
  task automatic applyNoise(input bit noise);
    if (noise) begin
      start_i = 1'($urandom);
      A_i     = 6'($urandom);
      B_i     = 6'($urandom);
      op_i    = 2'($urandom);
      sweep_i = 1'($urandom);
    end
  endtask

  // Runs one start through to IDLE; stallFixed >= 0 gives a fixed ready delay, otherwise random 0..3.
  task automatic applyStimulus(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op,
                               input logic sweep, input int stallFixed, input bit noise);
    logic [1:0]  ops[$];
    logic [11:0] expResult;
    logic        expDz;
    int          stall;
    int          lo;
    int          hi;

    lo = sweep ? 0 : int'(op);
    hi = sweep ? 3 : int'(op);
    for (int k = lo; k <= hi; k++) ops.push_back(2'(k));

    A_i = a; B_i = b; op_i = op; sweep_i = sweep; start_i = 1'b1;
    result_ready_i = 1'($urandom);
    step();
    start_i = 1'b0;
    expDz = 1'b0;

    foreach (ops[i]) begin
      checkOutput("drive.busy", 32'(busy_o), 32'd1);
      checkOutput("drive.valid", 32'(result_valid_o), 32'd0);
      checkOutput("drive.alu_A", 32'(alu_A_o), 32'(a));
      checkOutput("drive.alu_B", 32'(alu_B_o), 32'(b));
      checkOutput("drive.alu_op", 32'(alu_op_o), 32'(ops[i]));
      checkOutput("drive.div_zero", 32'(div_zero_o), 32'(expDz));
      applyNoise(noise);
      result_ready_i = 1'($urandom);
      step();
      checkOutput("sample.valid", 32'(result_valid_o), 32'd0);
      checkOutput("sample.busy", 32'(busy_o), 32'd1);
      applyNoise(noise);
      result_ready_i = 1'($urandom);
      step();

      expResult = aluModel(a, b, ops[i]);
`ifdef ALU_SCHED_DIVZERO_EN
      if (ops[i] == 2'b11 && b == 6'd0) begin
        expResult = 12'hFFF;
        expDz = 1'b1;
      end
`endif
      checkOutput("hold.valid", 32'(result_valid_o), 32'd1);
      checkOutput("hold.result", 32'(result_o), 32'(expResult));
      checkOutput("hold.result_op", 32'(result_op_o), 32'(ops[i]));
      checkOutput("hold.div_zero", 32'(div_zero_o), 32'(expDz));

      stall = (stallFixed >= 0) ? stallFixed : int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) begin
        result_ready_i = 1'b0;
        applyNoise(noise);
        step();
        checkOutput("stall.valid", 32'(result_valid_o), 32'd1);
        checkOutput("stall.result", 32'(result_o), 32'(expResult));
        checkOutput("stall.result_op", 32'(result_op_o), 32'(ops[i]));
      end

      result_ready_i = 1'b1;
      applyNoise(noise);
      if (noise && i == ops.size() - 1) start_i = 1'b1;
      step();
      result_ready_i = 1'b0;
      start_i = 1'b0;
    end

    checkOutput("done.busy", 32'(busy_o), 32'd0);
    checkOutput("done.valid", 32'(result_valid_o), 32'd0);
    checkOutput("done.div_zero", 32'(div_zero_o), 32'(expDz));
  endtask

  initial begin
    rst_i = 1'b1;
    step();
    step();
    checkAllZero("reset");
    rst_i = 1'b0;
    step();

    // Directed cases from the test plan.
    applyStimulus(6'd5, 6'd3, 2'b00, 1'b0, 0, 1'b0);
    applyStimulus(6'd7, 6'd2, 2'b11, 1'b0, 0, 1'b0);
    applyStimulus(6'd6, 6'd2, 2'b00, 1'b1, 10, 1'b1);
    applyStimulus(6'd9, 6'd0, 2'b11, 1'b0, 1, 1'b0);
    applyStimulus(6'd9, 6'd1, 2'b11, 1'b0, 0, 1'b0);
    applyStimulus(6'd63, 6'd63, 2'b10, 1'b1, 0, 1'b1);
    applyStimulus(6'd0, 6'd0, 2'b00, 1'b1, 2, 1'b0);

    // Reset during SAMPLE discards the in-flight result.
    A_i = 6'd5; B_i = 6'd3; op_i = 2'b10; sweep_i = 1'b0; start_i = 1'b1;
    result_ready_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    checkAllZero("midreset");
    rst_i = 1'b0;
    step();
    checkOutput("postreset.valid", 32'(result_valid_o), 32'd0);
    step();
    checkOutput("postreset.valid2", 32'(result_valid_o), 32'd0);
    result_ready_i = 1'b0;
    applyStimulus(6'd5, 6'd3, 2'b10, 1'b0, 0, 1'b0);

    // Randomized transactions, roughly one in eight with a zero divisor.
    for (int t = 0; t < 40; t++) begin
      logic [5:0] ra;
      logic [5:0] rb;
      ra = 6'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
      applyStimulus(ra, rb, 2'($urandom), 1'($urandom), -1, 1'($urandom));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
